// File: rtl/sramlike_ram_slave.sv
// Responder for the core's SRAM-like data bus: an internal word RAM behind an in-order outstanding queue.
// Define SRAMLIKE_RAM_STALL_EN to add LFSR-driven random refusal of requests (addr_ok backpressure).
module sramlike_ram_slave #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic [3:0]  pending
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam logic [3:0]    L_OUT  = 4'(OUTSTANDING);
  localparam logic [4:0]    L_LAT  = 5'(LATENCY);
  localparam logic [3:0]    L_SAT  = 4'(LATENCY);
  localparam logic [PW-1:0] L_LAST = PW'(OUTSTANDING - 1);

  logic [31:0]   r_mem   [DEPTH_WORDS];
  logic          r_qWr   [OUTSTANDING];
  logic [3:0]    r_qBe   [OUTSTANDING];
  logic [AW-1:0] r_qIdx  [OUTSTANDING];
  logic [31:0]   r_qData [OUTSTANDING];
  logic [3:0]    r_qAge  [OUTSTANDING];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [3:0]    r_count;
  logic          r_dataOk;
  logic [31:0]   r_rdata;

  logic          w_stall;
  logic          w_accept;
  logic          w_headValid;
  logic          w_headReady;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic          w_complete;
  logic [3:0]    w_inBe;
  logic [AW-1:0] w_inIdx;
  logic          w_cWr;
  logic [3:0]    w_cBe;
  logic [AW-1:0] w_cIdx;
  logic [31:0]   w_cData;
  logic          w_unusedAddr;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == L_LAST) ? '0 : p + 1'b1;
  endfunction

`ifdef SRAMLIKE_RAM_STALL_EN
  logic [15:0] r_lfsr;

  // Taps 16,14,13,11 in right-shift form; bit 0 doubles as the stall flag.
  always_ff @(posedge clk) begin
    if (rst) r_lfsr <= 16'hACE1;
    else     r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  end

  assign w_stall = r_lfsr[0];
`else
  assign w_stall = 1'b0;
`endif

  assign w_inIdx      = addr[AW+1:2];
  assign w_unusedAddr = ^addr[31:AW+2];

  always_comb begin
    w_inBe = 4'b1111;
    case (size)
      2'd0:    w_inBe = 4'b0001 << addr[1:0];
      2'd1:    w_inBe = addr[1] ? 4'b1100 : 4'b0011;
      default: w_inBe = 4'b1111;
    endcase
  end

  // Acceptance looks only at registered occupancy, so a full queue stays full
  // even in a cycle where its head is about to retire.
  assign addr_ok     = req && (r_count < L_OUT) && !w_stall;
  assign w_accept    = addr_ok;
  assign w_headValid = (r_count != 4'd0);
  assign w_headReady = w_headValid && (({1'b0, r_qAge[r_head]} + 5'd1) >= L_LAT);

  // With a one-cycle latency an incoming request into an empty queue retires at its own accept edge.
  assign w_bypass   = (LATENCY == 1) && w_accept && !w_headValid;
  assign w_push     = w_accept && !w_bypass;
  assign w_pop      = w_headReady;
  assign w_complete = w_pop || w_bypass;

  assign w_cWr   = w_pop ? r_qWr[r_head]   : wr;
  assign w_cBe   = w_pop ? r_qBe[r_head]   : w_inBe;
  assign w_cIdx  = w_pop ? r_qIdx[r_head]  : w_inIdx;
  assign w_cData = w_pop ? r_qData[r_head] : wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= nextPtr(r_tail);
      if (w_pop)  r_head <= nextPtr(r_head);
      r_count <= r_count + {3'b000, w_push} - {3'b000, w_pop};
    end
  end

  // Ages count edges since acceptance; the accept edge itself is the first, hence the load of 1.
  always_ff @(posedge clk) begin
    for (int i = 0; i < OUTSTANDING; i++) begin
      if (r_qAge[i] < L_SAT) r_qAge[i] <= r_qAge[i] + 4'd1;
    end
    if (w_push) begin
      r_qAge[r_tail]  <= 4'd1;
      r_qWr[r_tail]   <= wr;
      r_qBe[r_tail]   <= w_inBe;
      r_qIdx[r_tail]  <= w_inIdx;
      r_qData[r_tail] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dataOk <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_dataOk <= w_complete;
      r_rdata  <= (w_complete && !w_cWr) ? r_mem[w_cIdx] : '0;
    end
  end

  // RAM contents survive reset; only a store retiring outside reset touches them.
  always_ff @(posedge clk) begin
    if (!rst && w_complete && w_cWr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_cBe[b]) r_mem[w_cIdx][8*b +: 8] <= w_cData[8*b +: 8];
      end
    end
  end

  assign data_ok = r_dataOk;
  assign rdata   = r_rdata;
  assign pending = r_count;

endmodule

// File: tb/tb_sramlike_ram_slave.sv
// Randomised bench for sramlike_ram_slave against a completion-schedule reference model.
module tb_sramlike_ram_slave;

  localparam int DEPTH = 256;
  localparam int LAT   = 3;
  localparam int OUTS  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic [3:0]  pending;

  typedef struct {
    int          c;
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        modelQ[$];
  logic [31:0] modelMem   [DEPTH];
  bit          modelKnown [DEPTH];
  int          total   = 0;
  int          bad     = 0;
  int          cyc     = 0;
  int          lastC   = -1;
  bit          prevRst = 1'b1;

  sramlike_ram_slave #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT),
    .OUTSTANDING(OUTS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .wr     (wr),
    .size   (size),
    .addr   (addr),
    .wdata  (wdata),
    .addr_ok(addr_ok),
    .data_ok(data_ok),
    .rdata  (rdata),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int wordIndex(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // A store's lanes: bytes it names, taken from the same lane of its data.
  function automatic void modelStore(input req_t r);
    int          w;
    logic [31:0] word;
    bit          en;
    w    = wordIndex(r.addr);
    word = modelMem[w];
    for (int b = 0; b < 4; b++) begin
      if (r.size == 2'd0)      en = (b == int'(r.addr[1:0]));
      else if (r.size == 2'd1) en = ((b / 2) == int'(r.addr[1]));
      else                     en = 1'b1;
      if (en) word[8*b +: 8] = r.wdata[8*b +: 8];
    end
    modelMem[w] = word;
    if (r.size >= 2'd2) modelKnown[w] = 1'b1;
  endfunction

  // One bus cycle: drive, check the cycle's outputs against the model, then advance the model.
  task automatic applyStimulus(input bit iRst, input bit iReq, input bit iWr, input logic [1:0] iSize,
                               input logic [31:0] iAddr, input logic [31:0] iWdata, output bit accepted);
    req_t        r;
    req_t        n;
    bit          expOk;
    bit          expAddrOk;
    bit          known;
    logic [31:0] expData;
    rst   = iRst;
    req   = iReq;
    wr    = iWr;
    size  = iSize;
    addr  = iAddr;
    wdata = iWdata;
    @(negedge clk);
    expOk   = 1'b0;
    known   = 1'b0;
    expData = 32'h0;
    r       = '{c: 0, wr: 1'b0, size: 2'd0, addr: 32'h0, wdata: 32'h0};
    if (modelQ.size() > 0 && modelQ[0].c == cyc) begin
      r     = modelQ.pop_front();
      expOk = 1'b1;
      if (r.wr) begin
        modelStore(r);
      end else begin
        expData = modelMem[wordIndex(r.addr)];
        known   = modelKnown[wordIndex(r.addr)];
      end
    end
    expAddrOk = iReq && (modelQ.size() < OUTS);
    checkOutput("addr_ok", {31'b0, addr_ok}, {31'b0, expAddrOk});
    checkOutput("data_ok", {31'b0, data_ok}, {31'b0, expOk});
    checkOutput("pending", {28'b0, pending}, 32'(modelQ.size()));
    if (expOk && !r.wr && known) checkOutput("rdataLoad", rdata, expData);
    if (expOk && r.wr)           checkOutput("rdataStore", rdata, 32'h0);
    if (prevRst)                 checkOutput("rdataReset", rdata, 32'h0);
    accepted = 1'b0;
    if (iRst) begin
      modelQ.delete();
      lastC = cyc;
    end else if (expAddrOk) begin
      n.c     = (cyc + LAT > lastC + 1) ? cyc + LAT : lastC + 1;
      n.wr    = iWr;
      n.size  = iSize;
      n.addr  = iAddr;
      n.wdata = iWdata;
      modelQ.push_back(n);
      lastC    = n.c;
      accepted = 1'b1;
    end
    prevRst = iRst;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Holds req until the model says the request was taken (bounded).
  task automatic issue(input bit iWr, input logic [1:0] iSize, input logic [31:0] iAddr, input logic [31:0] iWdata);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 16 && !acc; i++) applyStimulus(1'b0, 1'b1, iWr, iSize, iAddr, iWdata, acc);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'd2, $urandom, $urandom, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && modelQ.size() > 0; i++) idle(1);
    idle(1);
  endtask

  initial begin
    bit acc;
    rst   = 1'b1;
    req   = 1'b1;
    wr    = 1'b0;
    size  = 2'd2;
    addr  = 32'h0;
    wdata = 32'h0;
    @(posedge clk);
    #1;

    // Reset with req held, then the first load goes in on release.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 32'h0, 32'h0, acc);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'd2, 32'h0, 32'h0, acc);
    drain();

    for (int i = 0; i < DEPTH; i++) issue(1'b1, 2'd2, 32'(i * 4), $urandom);
    drain();

    issue(1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
    idle(1);
    issue(1'b0, 2'd2, 32'h100, 32'h0);
    drain();

    issue(1'b1, 2'd2, 32'h200, 32'h11223344);
    issue(1'b1, 2'd0, 32'h201, 32'h55555555);
    issue(1'b0, 2'd2, 32'h200, 32'h0);
    issue(1'b1, 2'd1, 32'h202, 32'hABCDABCD);
    issue(1'b0, 2'd2, 32'h200, 32'h0);
    drain();

    issue(1'b1, 2'd2, 32'h300, 32'hCAFEF00D);
    issue(1'b0, 2'd2, 32'h300, 32'h0);
    drain();

    issue(1'b0, 2'd2, 32'h0, 32'h0);
    issue(1'b0, 2'd2, 32'h4, 32'h0);
    issue(1'b0, 2'd2, 32'h8, 32'h0);
    drain();

    issue(1'b1, 2'd2, 32'h100, 32'h0BADF00D);
    issue(1'b1, 2'd2, 32'h104, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, acc);
    idle(6);
    issue(1'b0, 2'd2, 32'h100, 32'h0);
    issue(1'b0, 2'd2, 32'h104, 32'h0);
    drain();

    for (int i = 0; i < 500; i++) begin
      applyStimulus($urandom_range(99) == 0, $urandom_range(9) < 7, 1'($urandom_range(1)),
                    2'($urandom_range(3)), $urandom, $urandom, acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
